// File: rtl/cpu_mem_responder_pkg.sv
// Shared types and constants for the core-side memory responder.
// Holds the dump FSM encoding and the fixed instruction/data constants.
package cpu_mem_responder_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DUMP  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [31:0] NOP_INST        = 32'h0000_0013;
    localparam logic [31:0] HALT_INST       = 32'h0000_0000;
    localparam int unsigned DMEM_BYTE_LIMIT = 8192;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cpu_mem_responder_dmem_bank.sv
// 64-bit data memory: one synchronous write port, an async read port for the
// core's load path and a second async read port feeding the dump stream.
module dmem_bank #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [63:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [63:0]   rdata,
    input  logic [AW-1:0] daddr,
    output logic [63:0]   ddata
);

    logic [63:0] mem_q [DEPTH];

    // No reset on the array: contents must survive a mid-dump reset.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];
    assign ddata = mem_q[daddr];

endmodule

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the pipelined core: instruction fetch, shared data
// bus with stores on the clock edge, and a post-halt valid/ready memory dump.
module cpu_mem_responder
    import cpu_mem_responder_pkg::*;
#(
    parameter int IMEM_DEPTH = 1024,
    parameter int DMEM_DEPTH = 1024,
    parameter int IAW        = $clog2(IMEM_DEPTH),
    parameter int DAW        = $clog2(DMEM_DEPTH)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [31:0]    pc,
    output logic [31:0]    inst,
    input  logic [63:0]    addr,
    input  logic           mem_rw,
    inout  wire  [63:0]    mem_data,
    input  logic           halt,
    input  logic           prog_we,
    input  logic [IAW-1:0] prog_addr,
    input  logic [31:0]    prog_data,
    output logic           dump_valid,
    input  logic           dump_ready,
    output logic [DAW-1:0] dump_addr,
    output logic [63:0]    dump_data,
    output logic           dump_done,
    output logic [15:0]    store_count
);

    state_e         state_q, state_d;
    logic [DAW-1:0] idx_q, idx_d;
    logic [15:0]    count_q, count_d;
    logic           store_en;
    logic [63:0]    load_data, dump_word;

    logic [31:0] imem_q [IMEM_DEPTH];

    // Program loading is only allowed while the core is held in reset.
    always_ff @(posedge clk) begin
        if (rst && prog_we) imem_q[prog_addr] <= prog_data;
    end

    assign inst = (pc >= 32'(4 * IMEM_DEPTH)) ? HALT_INST : imem_q[pc[IAW+1:2]];

    assign store_en = mem_rw && !rst && (addr < 64'(DMEM_BYTE_LIMIT))
                   && (state_q == ST_RUN || state_q == ST_DRAIN);

    dmem_bank #(.DEPTH(DMEM_DEPTH), .AW(DAW)) u_dmem (
        .clk   (clk),
        .we    (store_en),
        .waddr (addr[DAW+2:3]),
        .wdata (mem_data),
        .raddr (addr[DAW+2:3]),
        .rdata (load_data),
        .daddr (idx_q),
        .ddata (dump_word)
    );

    // Responder releases the bus whenever the core is driving a store.
    assign mem_data = mem_rw ? 64'bz : load_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            idx_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = store_en ? sat_inc16(count_q) : count_q;
        case (state_q)
            ST_RUN:   if (halt) state_d = ST_DRAIN;
            // One cycle lets a store issued alongside halt land before dumping.
            ST_DRAIN: begin
                state_d = ST_DUMP;
                idx_d   = '0;
            end
            ST_DUMP: begin
                if (dump_ready) begin
                    if (idx_q == DAW'(DMEM_DEPTH - 1)) state_d = ST_DONE;
                    else                                 idx_d   = idx_q + 1'b1;
                end
            end
            default:  state_d = ST_DONE;
        endcase
    end

    always_comb begin
        dump_valid = 1'b0;
        dump_done  = 1'b0;
        dump_data  = '0;
        case (state_q)
            ST_DUMP: begin
                dump_valid = 1'b1;
                dump_data  = dump_word;
            end
            ST_DONE: dump_done = 1'b1;
            default: ;
        endcase
    end

    assign dump_addr   = idx_q;
    assign store_count = count_q;

endmodule

// File: doc/cpu_mem_responder.md
# cpu_mem_responder

Memory-side responder for the five-stage RV64 pipeline core: answers the core's instruction fetch (`pc` → `inst`) and its bidirectional data bus (`mem_data`, `mem_rw`, `out_result` address). It holds the instruction and data memories and accepts stores on the clock edge. After the core signals `halt`, it drains and streams the whole data memory over a valid/ready dump port for verification. It sits beside the core in the top-level testbench/SoC wrapper.

## Interface
- `IMEM_DEPTH`, 1024, instruction words (32-bit); index = `pc[11:2]`
- `DMEM_DEPTH`, 1024, data doublewords (64-bit); index = `addr[12:3]`
- `clk`  in  1  core clock
- `rst`  in  1  asynchronous, active-high reset
- `pc`  in  32  fetch byte address from core
- `inst`  out  32  fetched instruction, combinational
- `addr`  in  64  data byte address (core's `out_result`, already clamped ≤ 8185)
- `mem_rw`  in  1  1 = core drives `mem_data` (store), 0 = responder drives (load)
- `mem_data`  inout  64  shared data bus
- `halt`  in  1  core halt indication (level)
- `prog_we`  in  1  instruction-load strobe, honoured only while `rst`=1
- `prog_addr`  in  10  instruction-load word index
- `prog_data`  in  32  instruction-load word
- `dump_valid`  out  1  dump word available
- `dump_ready`  in  1  consumer accepts dump word
- `dump_addr`  out  10  doubleword index of current dump word
- `dump_data`  out  64  current dump word
- `dump_done`  out  1  full memory streamed
- `store_count`  out  16  number of stores accepted, saturating

## Operation
- Fetch: `inst` = `imem[pc[11:2]]`, zero-latency; `pc` ≥ 4·`IMEM_DEPTH` returns 32'h0 (core's halt opcode).
- Load: when `mem_rw`=0, drive `mem_data` = `dmem[addr[12:3]]` combinationally; when `mem_rw`=1, `mem_data` = 'z.
- Store: at posedge `clk` with `mem_rw`=1, state RUN or DRAIN, write `mem_data` to `dmem[addr[12:3]]`; `addr[2:0]` ignored; `store_count` += 1, holds at 16'hFFFF.
- Read-during-write same index: combinational bus read is not applicable (responder tri-stated); a following-cycle load returns the new value.
- Program load: posedge `clk` with `rst`=1 and `prog_we`=1 writes `imem[prog_addr]`. Memory arrays are never cleared by reset.
- FSM states RUN, DRAIN, DUMP, DONE:
  - RUN → DRAIN when `halt`=1 sampled.
  - DRAIN → DUMP after exactly one cycle (absorbs any store in flight); index counter cleared to 0.
  - DUMP: `dump_valid`=1, `dump_addr`=index, `dump_data`=`dmem[index]`; on `dump_valid && dump_ready` index += 1; accept at index `DMEM_DEPTH`-1 → DONE.
  - DONE: `dump_valid`=0, `dump_done`=1; stays until reset. `halt` deasserting in DRAIN/DUMP/DONE is ignored.
- Stores in DUMP/DONE are dropped and not counted.

## Timing
- Reset values: state RUN, `dump_valid` 0, `dump_addr` 0, `dump_data` 0, `dump_done` 0, `store_count` 0; `inst`/`mem_data` follow memory contents combinationally.
- Fetch and load latency 0 cycles; store visible 1 cycle after the write edge.
- `halt` at edge N → DRAIN after N, DUMP after N+1, first `dump_valid` in cycle N+1..N+2; with `dump_ready` held 1, `dump_done` rises DMEM_DEPTH cycles after entering DUMP.
- `dump_data`/`dump_addr` stable while `dump_valid`=1 and `dump_ready`=0.
- `rst` mid-dump: immediately return to RUN, outputs to reset values; memories retain data.

## Structure
- Shared package: FSM state encoding, `NOP_INST` (32'h00000013), `HALT_INST` (32'h0), DMEM byte limit 8192.
- One sub-module: `dmem_bank` (64-bit array, sync write, async read, second async read port for dump). Instruction array and FSM stay in the top.

## Test plan
- Program load `imem[0]`=32'h00500093 under reset, release; `pc`=0 → `inst`=32'h00500093; `pc`=32'h1000 → 32'h0.
- Store `addr`=16, `mem_rw`=1, bus 64'hDEAD_BEEF_0000_0001; next cycle `mem_rw`=0, `addr`=20 → responder drives 64'hDEAD_BEEF_0000_0001; `store_count`=1.
- `mem_rw`=1 → responder output is 'z (no contention with core driver); `mem_rw`=0 → driven.
- Store in same cycle as `halt` rise, then store during DRAIN → both committed, appear in dump; store during DUMP dropped, count unchanged.
- Dump with `dump_ready` toggled 1/0 every cycle → 1024 words in order, no skips/duplicates, `dump_done` after index 1023 accepted.
- Assert `rst` at dump index 500 → state RUN, `dump_valid` 0, `store_count` 0; `dmem[2]` still holds previously stored value.
